// File: rtl/uart_word_ctrl.sv
// Byte-to-word bridge for a UART: assembles 8 received bytes into a 64-bit word
// and serialises 64-bit words into 8 transmitter bytes.
module uart_word_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter bit          MSB_FIRST      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [63:0] word_out,
    output logic        word_valid,
    input  logic        word_ready,
    input  logic [63:0] tx_word,
    input  logic        tx_word_valid,
    output logic        tx_word_ready,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_en,
    input  logic        uart_tx_busy,
    output logic        rx_overrun,
    output logic        rx_timeout
);

    localparam int unsigned IW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } tx_state_t;

    logic [2:0]    cnt_q, cnt_d, cnt_eff;
    logic [IW-1:0] idle_q, idle_d;
    logic [63:0]   asm_q, asm_d;
    logic [63:0]   word_q, word_d;
    logic          wv_q, wv_d;
    logic          ovr_q, ovr_d;
    logic          tmo_q, tmo_d;
    logic          done;

    tx_state_t     state_q;
    logic [63:0]   sh_q;
    logic [63:0]   sh_nx;
    logic [2:0]    idx_q;
    logic [1:0]    wcnt_q;
    logic [7:0]    txd_q;
    logic          txen_q;
    logic          txr_q;

    function automatic logic [7:0] head(input logic [63:0] w);
        return MSB_FIRST ? w[63:56] : w[7:0];
    endfunction

    // A timeout clears the byte count before this cycle's byte is counted.
    always_comb begin
        tmo_d   = (cnt_q != 3'd0) && (idle_q == IDLE_LAST);
        cnt_eff = tmo_d ? 3'd0 : cnt_q;
        asm_d   = asm_q;
        if (rx_valid) begin
            asm_d = MSB_FIRST ? {asm_q[55:0], rx_data}
                              : {rx_data, asm_q[63:8]};
        end
        cnt_d  = rx_valid ? cnt_eff + 3'd1 : cnt_eff;
        idle_d = (rx_valid || tmo_d || cnt_q == 3'd0) ? '0 : idle_q + 1'b1;
        done   = rx_valid && (cnt_eff == 3'd7);
        word_d = word_q;
        wv_d   = wv_q;
        ovr_d  = 1'b0;
        if (done) begin
            if (!wv_q || word_ready) begin
                word_d = asm_d;
                wv_d   = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (wv_q && word_ready) begin
            wv_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= 3'd0;
            idle_q <= '0;
            asm_q  <= 64'd0;
            word_q <= 64'd0;
            wv_q   <= 1'b0;
            ovr_q  <= 1'b0;
            tmo_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idle_q <= idle_d;
            asm_q  <= asm_d;
            word_q <= word_d;
            wv_q   <= wv_d;
            ovr_q  <= ovr_d;
            tmo_q  <= tmo_d;
        end
    end

    assign sh_nx = MSB_FIRST ? {sh_q[55:0], 8'h00} : {8'h00, sh_q[63:8]};

    // The next byte is loaded on entry to SEND so it is stable for the whole byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sh_q    <= 64'd0;
            idx_q   <= 3'd0;
            wcnt_q  <= 2'd0;
            txd_q   <= 8'd0;
            txen_q  <= 1'b0;
            txr_q   <= 1'b0;
        end else begin
            txen_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (txr_q && tx_word_valid) begin
                        sh_q    <= tx_word;
                        idx_q   <= 3'd0;
                        txd_q   <= head(tx_word);
                        txr_q   <= 1'b0;
                        state_q <= S_SEND;
                    end else begin
                        txr_q <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (!uart_tx_busy) begin
                        txen_q  <= 1'b1;
                        wcnt_q  <= 2'd0;
                        state_q <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: begin
                    if (uart_tx_busy || wcnt_q == 2'd3) begin
                        state_q <= S_WAIT_DONE;
                    end else begin
                        wcnt_q <= wcnt_q + 2'd1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!uart_tx_busy) begin
                        if (idx_q == 3'd7) begin
                            txr_q   <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            sh_q    <= sh_nx;
                            txd_q   <= head(sh_nx);
                            state_q <= S_SEND;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign word_out      = word_q;
    assign word_valid    = wv_q;
    assign rx_overrun    = ovr_q;
    assign rx_timeout    = tmo_q;
    assign tx_word_ready = txr_q;
    assign uart_tx_data  = txd_q;
    assign uart_tx_en    = txen_q;

endmodule
